qspi_sram_responder: RTL and testbench
======================================

// Module: qspi_sram_responder
// PURPOSE
// - FPGA-side emulation of a quad-SPI serial SRAM (SQI mode, 23LC1024-style), backed by on-chip block RAM.
// - Responds to the hack_soc QSPI initiator on any of its RAM, ROM or VRAM ports, so FPGA tests run without external SRAM chips.
// - Oversamples SCK, CS_N and SIO with the system clock. Does not use SCK as a clock.
// PARAMETERS
// - ADDR_WIDTH    16   memory size is 2**ADDR_WIDTH bytes; upper received address bits are ignored
// - INIT_FILE     ""   $readmemh image preloaded into memory; "" = no preload (contents undefined)
// - DUMMY_NIBBLES 2    SCK cycles between the last address nibble and the first read data nibble
// PORTS
// - clk        in   1  system clock; must be >= 4x SCK frequency
// - reset      in   1  synchronous, active-high
// - sck        in   1  serial clock from initiator
// - cs_n       in   1  chip select, active-low
// - sio_i      in   4  SIO[3:0] as driven by the initiator
// - sio_o      out  4  SIO[3:0] read data to the initiator
// - sio_oe     out  1  1 = responder drives SIO
// - busy       out  1  1 while a transaction is in progress (state != IDLE)
// - cmd_err    out  1  1-clk pulse when an unsupported command byte completes
// BEHAVIOUR
// - Input sampling
//   - sck, cs_n and sio_i are registered once, then edge-detected against a second register stage.
//   - SCK rise: sample sio. SCK fall: update sio_o.
//   - SCK high and SCK low must each last >= 2 clk.
// - Reset values: sio_o=0, sio_oe=0, busy=0, cmd_err=0, state=IDLE. Memory contents are NOT cleared by reset.
// - FSM states: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
//   - All fields are MSB nibble first; one nibble per SCK rise.
//   - IDLE -> CMD on cs_n falling.
//   - CMD: 2 nibbles.
//     - 0x03 -> ADDR (read).
//     - 0x02 -> ADDR (write).
//     - Other -> IGNORE, with cmd_err pulsed.
//   - ADDR: 6 nibbles (24-bit), then:
//     - write -> WRITE;
//     - read -> DUMMY, and the memory fetch is issued on the same clk.
//   - DUMMY: DUMMY_NIBBLES rises. The SCK fall after the last dummy rise sets sio_oe=1 and sio_o=data[7:4]; state -> READ.
//   - READ: each SCK fall drives the next nibble (high nibble, then low nibble).
//     - After the low nibble is sampled, the address increments and the next byte is prefetched.
//     - The fetch completes within 1 clk, well inside the SCK low half.
//   - WRITE: high then low nibble assemble a byte. The write is committed on the clk after the low-nibble rise; the address then increments.
//   - IGNORE: inputs ignored until cs_n rises.
// - Address arithmetic: addr <= (addr + 1) mod 2**ADDR_WIDTH. Sequential wrap from the top byte to 0 is seamless for both read and write.
// - cs_n rise, any state:
//   - state -> IDLE within 2 clk of the raw edge; sio_oe=0 on the same clk.
//   - A partial byte (high nibble only) is discarded and is never written.
// - SCK edges while cs_n is high are ignored.
// - reset while busy:
//   - Immediate IDLE and sio_oe=0.
//   - A write already committed is retained.
//   - A new transaction needs a fresh cs_n fall after reset is released.
// - sio_oe is never 1 outside READ. The responder never drives during CMD, ADDR or DUMMY.
// CONFIGURATION
// - Macro QSPI_SRAM_RESPONDER_MODE_REG_EN adds an 8-bit mode register, MR. MR reset value is 0x40 (sequential).
//   - Command WRMR 0x01 takes the next 2 nibbles into MR.
//   - Command RDMR 0x05 drives MR on the next 2 SCK falls, with no address or dummy phase.
//   - MR[7:6] selects address stepping:
//     - 00 byte: the address does not increment;
//     - 10 page: addr[4:0] wraps within a 32-byte page;
//     - 01/11 sequential.
// - Without the macro: 0x01 and 0x05 go to IGNORE with cmd_err pulsed; stepping is always sequential.
// TESTING
// - Write 0x02, addr 0x000010, data A5 3C, then read 0x03 at 0x000010 -> after 2 dummy SCK, sio reads A,5,3,C; sio_oe=1 only in data phase.
// - Write at addr 2**ADDR_WIDTH-1, data 11 22 -> mem[top]=0x11 and mem[0]=0x22 (wrap); reading from the top byte returns 11,22.
// - Write high nibble 0x7 only, then raise cs_n -> target byte unchanged; busy=0 and sio_oe=0 within 2 clk.
// - Command 0xAB -> cmd_err is a single 1-clk pulse, sio_oe stays 0 for the whole transaction, and memory is unchanged.
// - reset asserted mid-read -> sio_oe=0 and busy=0 on the next clk; a following read returns the previously written data.
// - With the macro: WRMR 0x00, write 3 bytes at 0x20 -> only mem[0x20] holds the last byte; RDMR returns 0x00.

Source files
------------

// File: rtl/qspi_sram_responder.sv
// qspi_sram_responder: quad-SPI (SQI) serial SRAM emulation backed by block RAM.
// SCK, CS_N and SIO are oversampled by clk; SCK is never used as a clock.
// Optional mode register (WRMR 0x01 / RDMR 0x05, address stepping modes) is
// enabled by defining QSPI_SRAM_RESPONDER_MODE_REG_EN.
module qspi_sram_responder #(
    parameter int ADDR_WIDTH    = 16,
    parameter     INIT_FILE     = "",
    parameter int DUMMY_NIBBLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic [3:0] sio_i,
    output logic [3:0] sio_o,
    output logic       sio_oe,
    output logic       busy,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] DUMMY_CNT = 8'(DUMMY_NIBBLES);
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
    localparam logic [7:0] CMD_WRMR  = 8'h01;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
`endif

    // Input synchronisers: stage 1 is the sampled value, stage 2 is used for edge detection
    logic       sck_s1, sck_s2, cs_s1, cs_s2;
    logic [3:0] sio_s1;

    state_t state_reg, state_next;

    logic [7:0]            nib_cnt_reg;
    logic                  nib_sel_reg;   // READ: 0 = high nibble on bus; WRITE: 1 = high nibble held
    logic                  is_write_reg;
    logic [ADDR_WIDTH-5:0] shift_reg;     // previous nibbles; only the low ADDR_WIDTH bits of an address matter
    logic [3:0]            hi_nib_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  wr_pend_reg;
    logic [7:0]            wr_data_reg;
    logic [7:0]            rd_data_reg;
    logic [3:0]            sio_o_reg;
    logic                  sio_oe_reg;
    logic                  cmd_err_reg;

    logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

    logic                  sck_rise, sck_fall, cs_rise, cs_fall;
    logic [7:0]            cmd_byte;
    logic [ADDR_WIDTH-1:0] addr_in, addr_inc, rd_addr;
    logic                  cmd_done, cmd_supported, addr_done, rd_advance, rd_en;
    logic [7:0]            rd_byte;

`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
    logic [7:0] mr_reg;
    logic       mr_wr_reg;    // current WRITE phase targets MR instead of memory
    logic       mr_rd_reg;    // current READ phase returns MR instead of memory
`endif

    // Next sequential address, honouring the stepping mode when MR exists
    function automatic logic [ADDR_WIDTH-1:0] addr_step(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [1:0] mode);
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
        case (mode)
            2'b00:   return a;
            2'b10:   return {a[ADDR_WIDTH-1:5], a[4:0] + 5'd1};
            default: return a + 1'b1;
        endcase
`else
        if (mode == 2'b00) return a + 1'b1;
        return a + 1'b1;
`endif
    endfunction

    assign sck_rise = sck_s1 & ~sck_s2 & ~cs_s1;
    assign sck_fall = ~sck_s1 & sck_s2 & ~cs_s1;
    assign cs_rise  = cs_s1 & ~cs_s2;
    assign cs_fall  = ~cs_s1 & cs_s2;

    assign cmd_byte  = {shift_reg[3:0], sio_s1};
    assign addr_in   = {shift_reg, sio_s1};
    assign cmd_done  = (state_reg == CMD) && sck_rise && (nib_cnt_reg == 8'd1);
    assign addr_done = (state_reg == ADDR) && sck_rise && (nib_cnt_reg == 8'd5);

`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
    assign cmd_supported = (cmd_byte == CMD_READ) || (cmd_byte == CMD_WRITE) ||
                           (cmd_byte == CMD_WRMR) || (cmd_byte == CMD_RDMR);
    assign addr_inc      = addr_step(addr_reg, mr_reg[7:6]);
    assign rd_advance    = (state_reg == READ) && sck_rise && nib_sel_reg && !mr_rd_reg;
    assign rd_byte       = mr_rd_reg ? mr_reg : rd_data_reg;
`else
    assign cmd_supported = (cmd_byte == CMD_READ) || (cmd_byte == CMD_WRITE);
    assign addr_inc      = addr_step(addr_reg, 2'b01);
    assign rd_advance    = (state_reg == READ) && sck_rise && nib_sel_reg;
    assign rd_byte       = rd_data_reg;
`endif

    // Fetch on the clk the address completes, and prefetch after each low nibble is sampled
    assign rd_en   = (addr_done && !is_write_reg) || rd_advance;
    assign rd_addr = addr_done ? addr_in : addr_inc;

    assign sio_o   = sio_o_reg;
    assign sio_oe  = sio_oe_reg;
    assign busy    = (state_reg != IDLE);
    assign cmd_err = cmd_err_reg;

    // Input sampling pipeline; deliberately not reset so a held-low cs_n is not seen as a new fall
    always_ff @(posedge clk) begin
        sck_s1 <= sck;
        sck_s2 <= sck_s1;
        cs_s1  <= cs_n;
        cs_s2  <= cs_s1;
        sio_s1 <= sio_i;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (cs_fall) state_next = CMD;
            CMD: begin
                if (cmd_done) begin
                    if (cmd_byte == CMD_READ || cmd_byte == CMD_WRITE) state_next = ADDR;
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
                    else if (cmd_byte == CMD_WRMR) state_next = WRITE;
                    else if (cmd_byte == CMD_RDMR) state_next = DUMMY;
`endif
                    else state_next = IGNORE;
                end
            end
            ADDR:   if (addr_done) state_next = is_write_reg ? WRITE : DUMMY;
            DUMMY:  if (sck_fall && nib_cnt_reg == DUMMY_CNT) state_next = READ;
            READ:   state_next = READ;
            WRITE: begin
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
                if (mr_wr_reg && sck_rise && nib_sel_reg) state_next = IGNORE;
`endif
            end
            IGNORE: state_next = IGNORE;
            default: state_next = IDLE;
        endcase
        if (cs_rise) state_next = IDLE;
    end

    // Datapath: nibble counting, address, output drive and write staging
    always_ff @(posedge clk) begin
        if (reset) begin
            nib_cnt_reg  <= '0;
            nib_sel_reg  <= 1'b0;
            is_write_reg <= 1'b0;
            shift_reg    <= '0;
            hi_nib_reg   <= '0;
            addr_reg     <= '0;
            wr_pend_reg  <= 1'b0;
            wr_data_reg  <= '0;
            sio_o_reg    <= '0;
            sio_oe_reg   <= 1'b0;
            cmd_err_reg  <= 1'b0;
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
            mr_reg       <= 8'h40;
            mr_wr_reg    <= 1'b0;
            mr_rd_reg    <= 1'b0;
`endif
        end else begin
            cmd_err_reg <= cmd_done && !cmd_supported;
            wr_pend_reg <= 1'b0;
            if (wr_pend_reg) addr_reg <= addr_inc;
            if (sck_rise) shift_reg <= {shift_reg[ADDR_WIDTH-9:0], sio_s1};

            case (state_reg)
                IDLE: begin
                    nib_cnt_reg <= '0;
                    nib_sel_reg <= 1'b0;
                    sio_oe_reg  <= 1'b0;
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
                    mr_wr_reg   <= 1'b0;
                    mr_rd_reg   <= 1'b0;
`endif
                end
                CMD: begin
                    if (sck_rise) nib_cnt_reg <= nib_cnt_reg + 8'd1;
                    if (cmd_done) begin
                        nib_cnt_reg  <= '0;
                        nib_sel_reg  <= 1'b0;
                        is_write_reg <= (cmd_byte == CMD_WRITE);
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
                        mr_wr_reg    <= (cmd_byte == CMD_WRMR);
                        mr_rd_reg    <= (cmd_byte == CMD_RDMR);
                        // RDMR has no dummy phase: next fall starts driving
                        if (cmd_byte == CMD_RDMR) nib_cnt_reg <= DUMMY_CNT;
`endif
                    end
                end
                ADDR: begin
                    if (sck_rise) nib_cnt_reg <= nib_cnt_reg + 8'd1;
                    if (addr_done) begin
                        nib_cnt_reg <= '0;
                        addr_reg    <= addr_in;
                    end
                end
                DUMMY: begin
                    if (sck_rise && nib_cnt_reg != DUMMY_CNT) nib_cnt_reg <= nib_cnt_reg + 8'd1;
                    if (sck_fall && nib_cnt_reg == DUMMY_CNT) begin
                        sio_oe_reg  <= 1'b1;
                        sio_o_reg   <= rd_byte[7:4];
                        nib_sel_reg <= 1'b0;
                    end
                end
                READ: begin
                    if (sck_fall) begin
                        sio_o_reg   <= nib_sel_reg ? rd_byte[7:4] : rd_byte[3:0];
                        nib_sel_reg <= ~nib_sel_reg;
                    end
                    if (rd_advance) addr_reg <= addr_inc;
                end
                WRITE: begin
                    if (sck_rise) begin
                        if (!nib_sel_reg) begin
                            hi_nib_reg  <= sio_s1;
                            nib_sel_reg <= 1'b1;
                        end else begin
                            nib_sel_reg <= 1'b0;
`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
                            if (mr_wr_reg) begin
                                mr_reg <= {hi_nib_reg, sio_s1};
                            end else begin
                                wr_pend_reg <= 1'b1;
                                wr_data_reg <= {hi_nib_reg, sio_s1};
                            end
`else
                            wr_pend_reg <= 1'b1;
                            wr_data_reg <= {hi_nib_reg, sio_s1};
`endif
                        end
                    end
                end
                default: ;
            endcase

            if (cs_rise) sio_oe_reg <= 1'b0;
        end
    end

    // Block RAM: write port commits staged bytes, read port is registered
    always_ff @(posedge clk) begin
        if (wr_pend_reg) mem[addr_reg] <= wr_data_reg;
        if (rd_en)       rd_data_reg   <= mem[rd_addr];
    end

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed testbench for qspi_sram_responder: one SCK cycle = 8 clk.
module tb_qspi_sram_responder;

    localparam int AW = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       cs_n;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic       sio_oe;
    logic       busy;
    logic       cmd_err;

    int n_assert = 0;
    int n_fail   = 0;
    int oe_bad   = 0;
    int err_cnt  = 0;
    bit data_phase = 1'b0;

    qspi_sram_responder #(
        .ADDR_WIDTH   (AW),
        .INIT_FILE    (""),
        .DUMMY_NIBBLES(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sck    (sck),
        .cs_n   (cs_n),
        .sio_i  (sio_i),
        .sio_o  (sio_o),
        .sio_oe (sio_oe),
        .busy   (busy),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Bus monitor: responder must never drive outside the data phase; count cmd_err cycles
    always @(negedge clk) begin
        if (sio_oe !== 1'b0 && !data_phase) oe_bad++;
        if (cmd_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One SCK cycle: drive sio during low half, sample responder mid-high
    task automatic cycle(input logic [3:0] d, output logic [3:0] q, output logic oe);
        sio_i = d;
        #40 sck = 1'b1;
        #20 q = sio_o;
        oe = sio_oe;
        #20 sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] q;
        logic       oe;
        cycle(b[7:4], q, oe);
        cycle(b[3:0], q, oe);
    endtask

    task automatic start_cmd(input logic [7:0] cmd, input logic [23:0] addr, input bit with_addr);
        cs_n = 1'b0;
        #40;
        send_byte(cmd);
        if (with_addr) begin
            send_byte(addr[23:16]);
            send_byte(addr[15:8]);
            send_byte(addr[7:0]);
        end
    endtask

    task automatic end_xfer();
        #40 cs_n = 1'b1;
        #40 data_phase = 1'b0;
    endtask

    task automatic write_seq(input logic [23:0] addr, input int n, input logic [31:0] data);
        start_cmd(8'h02, addr, 1'b1);
        for (int i = 0; i < n; i++) send_byte(data[8*(n-1-i) +: 8]);
        end_xfer();
    endtask

    task automatic read_seq(input string tag, input logic [23:0] addr, input int n,
                            input logic [31:0] exp);
        logic [3:0] q;
        logic       oe;
        start_cmd(8'h03, addr, 1'b1);
        for (int i = 0; i < 2; i++) cycle(4'h0, q, oe);
        data_phase = 1'b1;
        for (int i = 0; i < 2 * n; i++) begin
            cycle(4'h0, q, oe);
            check({tag, " nibble"}, 32'(q), 32'(exp[4*(2*n-1-i) +: 4]));
            check({tag, " oe"}, 32'(oe), 32'd1);
        end
        end_xfer();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] q;
        logic       oe;

        reset = 1'b1;
        sck   = 1'b0;
        cs_n  = 1'b1;
        sio_i = 4'h0;
        #50;
        check("reset sio_o",   32'(sio_o),   32'd0);
        check("reset sio_oe",  32'(sio_oe),  32'd0);
        check("reset busy",    32'(busy),    32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        reset = 1'b0;
        #40;

        // Basic write then read back
        start_cmd(8'h02, 24'h000010, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h3C);
        check("write busy", 32'(busy), 32'd1);
        end_xfer();
        check("write done busy", 32'(busy), 32'd0);
        read_seq("read 0x10", 24'h000010, 2, 32'h0000A53C);
        read_seq("read upper ignored", 24'hFF0010, 1, 32'h000000A5);

        // Wrap from top byte to 0
        write_seq(24'h00FFFF, 2, 32'h00001122);
        read_seq("wrap read top", 24'h00FFFF, 2, 32'h00001122);
        read_seq("wrap read zero", 24'h000000, 1, 32'h00000022);

        // Partial byte discarded on cs_n rise
        start_cmd(8'h02, 24'h000010, 1'b1);
        cycle(4'h7, q, oe);
        #40 cs_n = 1'b1;
        #20;
        check("partial busy", 32'(busy), 32'd0);
        check("partial oe", 32'(sio_oe), 32'd0);
        #40;
        read_seq("partial unchanged", 24'h000010, 1, 32'h000000A5);
        check("no cmd_err yet", 32'(err_cnt), 32'd0);

        // Unsupported command
        start_cmd(8'hAB, 24'h000010, 1'b1);
        send_byte(8'hFF);
        check("ignore busy", 32'(busy), 32'd1);
        end_xfer();
        check("cmd_err pulse count", 32'(err_cnt), 32'd1);
        read_seq("after bad cmd", 24'h000010, 2, 32'h0000A53C);

        // Reset in the middle of a read
        start_cmd(8'h03, 24'h000011, 1'b1);
        cycle(4'h0, q, oe);
        cycle(4'h0, q, oe);
        data_phase = 1'b1;
        cycle(4'h0, q, oe);
        check("mid-read first nibble", 32'(q), 32'h3);
        reset = 1'b1;
        #10;
        check("reset mid-read oe", 32'(sio_oe), 32'd0);
        check("reset mid-read busy", 32'(busy), 32'd0);
        #20 reset = 1'b0;
        cycle(4'h0, q, oe);
        check("no restart without cs fall", 32'(busy), 32'd0);
        #40 cs_n = 1'b1;
        #40 data_phase = 1'b0;
        read_seq("read after reset", 24'h000011, 1, 32'h0000003C);

`ifdef QSPI_SRAM_RESPONDER_MODE_REG_EN
        // Byte-mode stepping via the mode register
        write_seq(24'h000020, 3, 32'h00010203);
        start_cmd(8'h01, 24'h0, 1'b0);
        send_byte(8'h00);
        end_xfer();
        write_seq(24'h000020, 3, 32'h00AABBCC);
        start_cmd(8'h05, 24'h0, 1'b0);
        data_phase = 1'b1;
        cycle(4'h0, q, oe);
        check("rdmr high", 32'(q), 32'h0);
        check("rdmr oe", 32'(oe), 32'd1);
        cycle(4'h0, q, oe);
        check("rdmr low", 32'(q), 32'h0);
        end_xfer();
        start_cmd(8'h01, 24'h0, 1'b0);
        send_byte(8'h40);
        end_xfer();
        read_seq("byte mode result", 24'h000020, 3, 32'h00CC0203);
        check("mode cmds no cmd_err", 32'(err_cnt), 32'd1);
`else
        // Mode-register commands are unsupported in this build
        start_cmd(8'h01, 24'h0, 1'b0);
        send_byte(8'h00);
        end_xfer();
        check("wrmr unsupported cmd_err", 32'(err_cnt), 32'd2);
        read_seq("seq after wrmr", 24'h000010, 2, 32'h0000A53C);
`endif

        check("sio_oe outside data phase", 32'(oe_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
